// File: rtl/bin_pkg.sv
// -----------------------------------------------------------------------------
// bin_pkg -- shared definitions for the bin_arbiter shared-adder block.
//
// Contents:
//   NREQ_DEFAULT / W_DEFAULT : default requester count and operand width
//   NREQ_MAX                 : widest requester count the pick function handles
//   out_state_e              : state of the single output register (EMPTY/FULL)
//   rr_onehot()              : round-robin one-hot pick starting at a pointer
// -----------------------------------------------------------------------------
package bin_pkg;

    localparam int NREQ_DEFAULT = 4;
    localparam int W_DEFAULT    = 32;
    localparam int NREQ_MAX     = 8;

    typedef enum logic {
        OUT_EMPTY = 1'b0,
        OUT_FULL  = 1'b1
    } out_state_e;

    // Scan n requesters starting at ptr, wrapping n-1 -> 0, and return the
    // first valid one as a one-hot vector (all zero when nothing is valid).
    function automatic logic [NREQ_MAX-1:0] rr_onehot(
        input logic [NREQ_MAX-1:0] valid,
        input logic [2:0]          ptr,
        input int                  n
    );
        logic [NREQ_MAX-1:0] pick;
        logic                found;
        int                  idx;
        pick  = '0;
        found = 1'b0;
        for (int k = 0; k < NREQ_MAX; k++) begin
            if (k < n) begin
                idx = (int'(ptr) + k) % n;
                if (!found && valid[idx]) begin
                    pick[idx] = 1'b1;
                    found     = 1'b1;
                end
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// -----------------------------------------------------------------------------
// rr_pick -- combinational pointer-rotated priority encoder.
//
// Ports:
//   valid_i [NREQ-1:0] : request vector
//   ptr_i   [PW-1:0]   : index where the search starts
//   grant_o [NREQ-1:0] : one-hot pick of the first valid index at/after ptr_i
// -----------------------------------------------------------------------------
module rr_pick
    import bin_pkg::*;
#(
    parameter int NREQ = NREQ_DEFAULT,
    parameter int PW   = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] valid_i,
    input  logic [PW-1:0]   ptr_i,
    output logic [NREQ-1:0] grant_o
);

    logic [NREQ_MAX-1:0] valid_ext;
    logic [NREQ_MAX-1:0] pick_ext;
    logic                unused_pick;

    always_comb begin
        valid_ext             = '0;
        valid_ext[NREQ-1:0]   = valid_i;
        pick_ext              = rr_onehot(valid_ext, 3'(ptr_i), NREQ);
    end

    assign grant_o = pick_ext[NREQ-1:0];

    // Bits above NREQ can never be picked because their valid bits are zero.
    assign unused_pick = ^pick_ext;

endmodule

// File: rtl/bin_arbiter.sv
// -----------------------------------------------------------------------------
// bin_arbiter -- NREQ requesters share one W-bit adder through round-robin
// arbitration and a single registered result slot.
//
// Ports:
//   clk, rst                 : clock, synchronous active-high reset
//   req_valid [NREQ-1:0]     : requester i has an add pending
//   req_a/req_b [NREQ*W-1:0] : operands, slice i belongs to requester i
//   req_ready [NREQ-1:0]     : one-hot grant, operands taken this cycle
//   resp_valid [NREQ-1:0]    : one-hot owner of the registered result
//   resp_ready [NREQ-1:0]    : requester i accepts its result this cycle
//   result [W-1:0], carry    : registered sum and carry-out
//   dbg_ptr, dbg_full        : round-robin pointer and output-slot state
//
// Handshake: a request transfers when req_valid[i] && req_ready[i]; a response
// transfers when resp_valid[i] && resp_ready[i]. Requesters hold operands
// until granted. Only the owner's resp_ready is looked at.
// -----------------------------------------------------------------------------
module bin_arbiter
    import bin_pkg::*;
#(
    parameter int NREQ = NREQ_DEFAULT,
    parameter int W    = W_DEFAULT
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NREQ-1:0]         req_valid,
    input  logic [NREQ*W-1:0]       req_a,
    input  logic [NREQ*W-1:0]       req_b,
    output logic [NREQ-1:0]         req_ready,
    output logic [NREQ-1:0]         resp_valid,
    input  logic [NREQ-1:0]         resp_ready,
    output logic [W-1:0]            result,
    output logic                    carry,
    output logic [$clog2(NREQ)-1:0] dbg_ptr,
    output logic                    dbg_full
);

    localparam int PW = $clog2(NREQ);

    logic [NREQ-1:0] resp_valid_q, resp_valid_d;
    logic [W-1:0]    result_q, result_d;
    logic            carry_q, carry_d;
    logic [PW-1:0]   ptr_q, ptr_d;

    out_state_e      out_state;
    logic            owner_ready;
    logic            grant_en;
    logic [NREQ-1:0] pick;
    logic [NREQ-1:0] grant;
    logic [W-1:0]    a_sel, b_sel;
    logic [PW-1:0]   gnt_idx;
    logic [W:0]      sum;

    rr_pick #(
        .NREQ (NREQ),
        .PW   (PW)
    ) u_pick (
        .valid_i (req_valid),
        .ptr_i   (ptr_q),
        .grant_o (pick)
    );

    assign out_state   = (|resp_valid_q) ? OUT_FULL : OUT_EMPTY;
    assign owner_ready = |(resp_valid_q & resp_ready);

    // Operand mux driven by the one-hot grant, then the single shared adder.
    always_comb begin
        a_sel   = '0;
        b_sel   = '0;
        gnt_idx = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant[i]) begin
                a_sel   = req_a[i*W +: W];
                b_sel   = req_b[i*W +: W];
                gnt_idx = PW'(i);
            end
        end
    end

    assign sum = {1'b0, a_sel} + {1'b0, b_sel};

    // Output-slot FSM: next state and grant decision.
    always_comb begin
        resp_valid_d = resp_valid_q;
        result_d     = result_q;
        carry_d      = carry_q;
        ptr_d        = ptr_q;
        grant_en     = 1'b0;

        case (out_state)
            OUT_EMPTY: grant_en = 1'b1;
            OUT_FULL:  grant_en = owner_ready;  // drain and refill same cycle
            default:   grant_en = 1'b0;
        endcase

        // No grants leak out while reset is held.
        if (rst) begin
            grant_en = 1'b0;
        end

        grant = grant_en ? pick : '0;

        if (|grant) begin
            resp_valid_d = grant;
            result_d     = sum[W-1:0];
            carry_d      = sum[W];
            ptr_d        = (gnt_idx == PW'(NREQ - 1)) ? '0 : gnt_idx + 1'b1;
        end else if (out_state == OUT_FULL && owner_ready) begin
            // Drain with nothing new: result and carry keep their last value.
            resp_valid_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            resp_valid_q <= '0;
            result_q     <= '0;
            carry_q      <= 1'b0;
            ptr_q        <= '0;
        end else begin
            resp_valid_q <= resp_valid_d;
            result_q     <= result_d;
            carry_q      <= carry_d;
            ptr_q        <= ptr_d;
        end
    end

    assign req_ready  = grant;
    assign resp_valid = resp_valid_q;
    assign result     = result_q;
    assign carry      = carry_q;
    assign dbg_ptr    = ptr_q;
    assign dbg_full   = (out_state == OUT_FULL);

endmodule

// File: tb/tb_bin_arbiter.sv
// -----------------------------------------------------------------------------
// tb_bin_arbiter -- directed self-checking bench for bin_arbiter (NREQ=4, W=32).
// Inputs change just after the falling edge; combinational outputs are checked
// 1 time unit later, registered outputs at the following falling edge.
// -----------------------------------------------------------------------------
module tb_bin_arbiter;

    localparam int NREQ = 4;
    localparam int W    = 32;

    logic              clk;
    logic              rst;
    logic [NREQ-1:0]   req_valid;
    logic [NREQ*W-1:0] req_a;
    logic [NREQ*W-1:0] req_b;
    logic [NREQ-1:0]   req_ready;
    logic [NREQ-1:0]   resp_valid;
    logic [NREQ-1:0]   resp_ready;
    logic [W-1:0]      result;
    logic              carry;
    logic [1:0]        dbg_ptr;
    logic              dbg_full;

    int n_assert;
    int n_fail;

    bin_arbiter #(
        .NREQ (NREQ),
        .W    (W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_a      (req_a),
        .req_b      (req_b),
        .req_ready  (req_ready),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .result     (result),
        .carry      (carry),
        .dbg_ptr    (dbg_ptr),
        .dbg_full   (dbg_full)
    );

    // ---------------- clock / reset ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- driver helpers ----------------
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic set_op(input int i, input logic [W-1:0] a, input logic [W-1:0] b);
        req_a[i*W +: W] = a;
        req_b[i*W +: W] = b;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        logic [3:0]  exp_g;
        logic [31:0] exp_sum;
        n_assert   = 0;
        n_fail     = 0;
        rst        = 1'b1;
        req_valid  = 4'b1111;
        req_a      = '0;
        req_b      = '0;
        resp_ready = 4'b0000;

        // Reset state, with every requester asking: nothing may be granted.
        tick();
        tick();
        #1;
        check("rst_req_ready", 64'(req_ready), 64'h0);
        check("rst_resp_valid", 64'(resp_valid), 64'h0);
        check("rst_result", 64'(result), 64'h0);
        check("rst_carry", 64'(carry), 64'h0);
        check("rst_ptr", 64'(dbg_ptr), 64'h0);

        // Single add: 3 + 4 on requester 0.
        @(negedge clk);
        rst       = 1'b0;
        req_valid = 4'b0001;
        set_op(0, 32'd3, 32'd4);
        #1;
        check("basic_grant", 64'(req_ready), 64'h1);
        tick();
        req_valid = 4'b0000;
        check("basic_resp_valid", 64'(resp_valid), 64'h1);
        check("basic_result", 64'(result), 64'd7);
        check("basic_carry", 64'(carry), 64'h0);
        check("basic_ptr", 64'(dbg_ptr), 64'h1);

        // Drain with no new request: resp_valid clears, result holds.
        resp_ready = 4'b1111;
        #1;
        check("drain_no_grant", 64'(req_ready), 64'h0);
        tick();
        check("drain_resp_valid", 64'(resp_valid), 64'h0);
        check("drain_result_hold", 64'(result), 64'd7);
        check("drain_empty", 64'(dbg_full), 64'h0);

        // Overflow on requester 1: 0xFFFFFFFF + 2.
        resp_ready = 4'b0000;
        req_valid  = 4'b0010;
        set_op(1, 32'hFFFF_FFFF, 32'd2);
        #1;
        check("ovf_grant", 64'(req_ready), 64'h2);
        tick();
        check("ovf_result", 64'(result), 64'd1);
        check("ovf_carry", 64'(carry), 64'h1);
        check("ovf_resp_valid", 64'(resp_valid), 64'h2);

        // Back-to-back: owner 1 drains while requester 2 is granted.
        resp_ready = 4'b0010;
        req_valid  = 4'b0100;
        set_op(2, 32'd5, 32'd6);
        #1;
        check("b2b_grant", 64'(req_ready), 64'h4);
        tick();
        check("b2b_resp_valid", 64'(resp_valid), 64'h4);
        check("b2b_result", 64'(result), 64'd11);
        check("b2b_carry", 64'(carry), 64'h0);
        check("b2b_ptr", 64'(dbg_ptr), 64'd3);

        // Backpressure: owner 2 not ready, other ready bits high and ignored.
        req_valid  = 4'b0010;
        set_op(1, 32'd20, 32'd22);
        resp_ready = 4'b1011;
        for (int c = 0; c < 3; c++) begin
            #1;
            check("bp_no_grant", 64'(req_ready), 64'h0);
            tick();
            check("bp_resp_hold", 64'(resp_valid), 64'h4);
            check("bp_result_hold", 64'(result), 64'd11);
        end
        resp_ready = 4'b0100;
        #1;
        check("bp_release_grant", 64'(req_ready), 64'h2);
        tick();
        check("bp_release_resp", 64'(resp_valid), 64'h2);
        check("bp_release_result", 64'(result), 64'd42);
        check("bp_release_ptr", 64'(dbg_ptr), 64'd2);

        // Get requester 2 to own the slot, then reset mid-operation.
        resp_ready = 4'b0010;
        req_valid  = 4'b0100;
        set_op(2, 32'd1, 32'd1);
        tick();
        check("pre_rst_resp", 64'(resp_valid), 64'h4);
        check("pre_rst_result", 64'(result), 64'd2);
        rst        = 1'b1;
        req_valid  = 4'b0000;
        resp_ready = 4'b0000;
        tick();
        check("midrst_resp_valid", 64'(resp_valid), 64'h0);
        check("midrst_result", 64'(result), 64'h0);
        check("midrst_carry", 64'(carry), 64'h0);
        check("midrst_ptr", 64'(dbg_ptr), 64'h0);
        rst       = 1'b0;
        req_valid = 4'b1010;
        #1;
        check("post_rst_lowest", 64'(req_ready), 64'h2);

        // Round robin: all requesters valid, all resp_ready high.
        req_valid  = 4'b1111;
        resp_ready = 4'b1111;
        for (int i = 0; i < NREQ; i++) begin
            set_op(i, 32'(i + 10), 32'(i * 100));
        end
        for (int k = 0; k < 5; k++) begin
            exp_g   = 4'b0001 << (k % 4);
            exp_sum = 32'((k % 4) + 10 + (k % 4) * 100);
            #1;
            check("rr_grant", 64'(req_ready), 64'(exp_g));
            tick();
            check("rr_resp_valid", 64'(resp_valid), 64'(exp_g));
            check("rr_result", 64'(result), 64'(exp_sum));
        end

        // Requester 3 alone, re-requesting each cycle; pointer wraps 3 -> 0.
        req_valid = 4'b1000;
        set_op(3, 32'd7, 32'd8);
        for (int k = 0; k < 3; k++) begin
            #1;
            check("solo3_grant", 64'(req_ready), 64'h8);
            tick();
            check("solo3_resp", 64'(resp_valid), 64'h8);
            check("solo3_result", 64'(result), 64'd15);
            check("solo3_ptr", 64'(dbg_ptr), 64'h0);
        end
        set_op(3, 32'h8000_0000, 32'h8000_0000);
        #1;
        check("solo3_ovf_grant", 64'(req_ready), 64'h8);
        tick();
        check("solo3_ovf_result", 64'(result), 64'h0);
        check("solo3_ovf_carry", 64'(carry), 64'h1);

        // Final drain.
        req_valid = 4'b0000;
        tick();
        check("final_empty", 64'(resp_valid), 64'h0);
        check("final_carry_hold", 64'(carry), 64'h1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
